// File: rtl/corr_pkg.sv
// Shared types and helpers for the correlation sample loader.
package corr_pkg;

  // One complex sample; re sits in the low byte so a packed pair reads {im, re}.
  typedef struct packed {
    logic [7:0] im;
    logic [7:0] re;
  } sample_t;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_WAIT_RDY,
    ST_WRITE,
    ST_START
  } state_t;

  // Number of complex elements in one emitted vector.
  function automatic int calc_mul_num(input int chnum, input int twidth);
    return chnum * twidth;
  endfunction

  // Two elements per 32-bit word, rounding up.
  function automatic int calc_nwords(input int mul_num);
    return (mul_num + 1) / 2;
  endfunction

  // Element 2k in the low half, element 2k+1 in the high half.
  function automatic logic [31:0] pack_word(input sample_t lo, input sample_t hi);
    return {hi.im, hi.re, lo.im, lo.re};
  endfunction

endpackage

// File: rtl/mem_split32.sv
// Split-bus 32-bit memory port: request/write-enable/address/data out, ack back.
interface MemSplit32;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ack;

  modport Master (output req, output we, output addr, output data, input ack);
  modport Slave  (input req, input we, input addr, input data, output ack);
endinterface

// File: rtl/corr_win_shreg.sv
// Per-channel sliding window: tap 0 holds the newest sample.
module corr_win_shreg
  import corr_pkg::*;
#(
  parameter int TWIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  sample_t                din,
  output sample_t [TWIDTH-1:0]   taps
);

  sample_t [TWIDTH-1:0] taps_reg;

  // Newest sample enters tap 0 on each enabled beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      taps_reg[0] <= '0;
    end else if (en) begin
      taps_reg[0] <= din;
    end
  end

  for (genvar gi = 1; gi < TWIDTH; gi++) begin : g_tap
    // Older taps take the value of their younger neighbour.
    always_ff @(posedge clk) begin
      if (!rst) begin
        taps_reg[gi] <= '0;
      end else if (en) begin
        taps_reg[gi] <= taps_reg[gi-1];
      end
    end
  end

  assign taps = taps_reg;

endmodule

// File: rtl/corr_sample_loader.sv
// Collects per-channel sample windows, writes each new window into the
// correlation engine's sample region and then pulses the engine start.
module corr_sample_loader
  import corr_pkg::*;
#(
  parameter  int FIFO_BASE_ADDR = 99,
  parameter  int TWIDTH         = 3,
  parameter  int CHNUM          = 2,
  parameter  int INT_LENGTH     = 10,
  parameter  int IDWIDTH        = 8,
  localparam int VEC_W          = $clog2(INT_LENGTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     smpl_valid_i,
  output logic                     smpl_ready_o,
  input  logic [CHNUM*IDWIDTH-1:0] smpl_re_i,
  input  logic [CHNUM*IDWIDTH-1:0] smpl_im_i,
  input  logic                     clear_i,
  MemSplit32.Master                mif,
  input  logic                     acc_ready_i,
  output logic                     acc_start_o,
  output logic                     acc_last_o,
  output logic [VEC_W-1:0]         vec_cnt_o
);

  localparam int MUL_NUM = calc_mul_num(CHNUM, TWIDTH);
  localparam int NWORDS  = calc_nwords(MUL_NUM);
  localparam int WIDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int FILL_W  = $clog2(TWIDTH + 1);

  if (IDWIDTH != 8) begin : g_bad_idwidth
    $error("corr_sample_loader: IDWIDTH must be 8");
  end

  state_t            state_reg, state_next;
  logic [FILL_W-1:0] fill_reg, fill_next, fill_inc;
  logic [VEC_W-1:0]  vec_reg, vec_next, vec_inc;
  logic [WIDX_W-1:0] widx_reg, widx_next;
  logic [WIDX_W:0]   lo_idx, hi_idx;
  logic              accept;
  logic [31:0]       wr_word;
  sample_t           elem [2*NWORDS];

  // A beat is taken only in COLLECT and never alongside a clear.
  assign smpl_ready_o = (state_reg == ST_COLLECT);
  assign accept       = smpl_valid_i & smpl_ready_o & ~clear_i;

  for (genvar gi = 0; gi < CHNUM; gi++) begin : g_ch
    sample_t              din;
    sample_t [TWIDTH-1:0] taps;

    assign din.re = smpl_re_i[gi*8 +: 8];
    assign din.im = smpl_im_i[gi*8 +: 8];

    corr_win_shreg #(.TWIDTH(TWIDTH)) u_win (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (din),
      .taps (taps)
    );

    for (genvar gj = 0; gj < TWIDTH; gj++) begin : g_tap
      assign elem[gi*TWIDTH + gj] = taps[gj];
    end
  end

  // With an odd element count the last word's upper half stays zero.
  if ((MUL_NUM % 2) != 0) begin : g_pad
    assign elem[MUL_NUM] = '0;
  end

  assign lo_idx   = {widx_reg, 1'b0};
  assign hi_idx   = {widx_reg, 1'b1};
  assign wr_word  = pack_word(elem[lo_idx], elem[hi_idx]);
  assign fill_inc = (fill_reg == FILL_W'(TWIDTH)) ? fill_reg : fill_reg + 1'b1;
  assign vec_inc  = vec_reg + 1'b1;
  assign vec_cnt_o = vec_reg;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_COLLECT;
      fill_reg  <= '0;
      vec_reg   <= '0;
      widx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      vec_reg   <= vec_next;
      widx_reg  <= widx_next;
    end
  end

  // Next-state logic and bus/start outputs; a clear overrides everything.
  always_comb begin
    state_next  = state_reg;
    fill_next   = fill_reg;
    vec_next    = vec_reg;
    widx_next   = widx_reg;
    mif.req     = 1'b0;
    mif.we      = 1'b0;
    mif.addr    = '0;
    mif.data    = '0;
    acc_start_o = 1'b0;
    acc_last_o  = 1'b0;

    case (state_reg)
      ST_COLLECT: begin
        if (accept) begin
          fill_next = fill_inc;
          if (fill_inc == FILL_W'(TWIDTH)) begin
            state_next = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (acc_ready_i) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mif.req  = 1'b1;
        mif.we   = 1'b1;
        mif.addr = 32'(FIFO_BASE_ADDR) + 32'(widx_reg);
        mif.data = wr_word;
        if (mif.ack) begin
          if (widx_reg == WIDX_W'(NWORDS - 1)) begin
            widx_next  = '0;
            state_next = ST_START;
          end else begin
            widx_next = widx_reg + 1'b1;
          end
        end
      end
      ST_START: begin
        acc_start_o = 1'b1;
        state_next  = ST_COLLECT;
        if (vec_inc == VEC_W'(INT_LENGTH)) begin
          acc_last_o = 1'b1;
          vec_next   = '0;
        end else begin
          vec_next = vec_inc;
        end
      end
      default: state_next = ST_COLLECT;
    endcase

    if (clear_i) begin
      state_next  = ST_COLLECT;
      fill_next   = '0;
      vec_next    = '0;
      widx_next   = '0;
      acc_start_o = 1'b0;
      acc_last_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_corr_sample_loader.sv
// Directed bench for corr_sample_loader (CHNUM=2, TWIDTH=3, INT_LENGTH=2).
module tb_corr_sample_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        smpl_valid_i;
  logic        smpl_ready_o;
  logic [15:0] smpl_re_i;
  logic [15:0] smpl_im_i;
  logic        clear_i;
  logic        acc_ready_i;
  logic        acc_start_o;
  logic        acc_last_o;
  logic [1:0]  vec_cnt_o;
  logic        ack_en;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  MemSplit32 mif ();
  assign mif.ack = ack_en;

  corr_sample_loader #(
    .FIFO_BASE_ADDR (99),
    .TWIDTH         (3),
    .CHNUM          (2),
    .INT_LENGTH     (2),
    .IDWIDTH        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .smpl_valid_i (smpl_valid_i),
    .smpl_ready_o (smpl_ready_o),
    .smpl_re_i    (smpl_re_i),
    .smpl_im_i    (smpl_im_i),
    .clear_i      (clear_i),
    .mif          (mif),
    .acc_ready_i  (acc_ready_i),
    .acc_start_o  (acc_start_o),
    .acc_last_o   (acc_last_o),
    .vec_cnt_o    (vec_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every completed word (req & ack) mid-cycle.
  always @(negedge clk) begin
    if (mif.req === 1'b1 && mif.ack === 1'b1 && mif.we === 1'b1) begin
      wr_addr_q.push_back(mif.addr);
      wr_data_q.push_back(mif.data);
      $display("[%0d] write addr=%0d data=%08h", cyc, mif.addr, mif.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present beat n (ch0 re=n im=0x10+n, ch1 re=0x20+n im=0x30+n) until accepted.
  task automatic send_beat(input logic [7:0] n, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = 0;
    @(negedge clk);
    smpl_valid_i = 1'b1;
    smpl_re_i = {8'h20 + n, n};
    smpl_im_i = {8'h30 + n, 8'h10 + n};
    for (int i = 0; i < 100; i++) begin
      if (smpl_ready_o === 1'b1) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    smpl_valid_i = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL beat_accept: beat %0d not accepted, got ready=%0b want 1", n, smpl_ready_o);
    end
    $display("[%0d] beat n=%0d accepted=%0b", cyc, n, ok);
  endtask

  // Wait (bounded) for the start pulse; returns at the negedge where it is high.
  task automatic wait_start(output int st_cyc, output logic last);
    bit ok;
    ok = 1'b0;
    st_cyc = 0;
    last = 1'bx;
    for (int i = 0; i < 100; i++) begin
      if (acc_start_o === 1'b1) begin
        ok = 1'b1;
        st_cyc = cyc;
        last = acc_last_o;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL start_timeout: got no acc_start_o want a pulse");
    end else begin
      $display("[%0d] start last=%0b", cyc, last);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (smpl_ready_o !== 1'b1) $display("FAIL reset_ready: got %0b want 1", smpl_ready_o); else pass_cnt++;
    total_cnt++; if (mif.req !== 1'b0) $display("FAIL reset_req: got %0b want 0", mif.req); else pass_cnt++;
    total_cnt++; if (mif.we !== 1'b0) $display("FAIL reset_we: got %0b want 0", mif.we); else pass_cnt++;
    total_cnt++; if (mif.addr !== 32'd0) $display("FAIL reset_addr: got %0d want 0", mif.addr); else pass_cnt++;
    total_cnt++; if (mif.data !== 32'd0) $display("FAIL reset_data: got %08h want 0", mif.data); else pass_cnt++;
    total_cnt++; if (acc_start_o !== 1'b0) $display("FAIL reset_start: got %0b want 0", acc_start_o); else pass_cnt++;
    total_cnt++; if (acc_last_o !== 1'b0) $display("FAIL reset_last: got %0b want 0", acc_last_o); else pass_cnt++;
    total_cnt++; if (vec_cnt_o !== 2'd0) $display("FAIL reset_vec: got %0d want 0", vec_cnt_o); else pass_cnt++;
  endtask

  task automatic test_fill_pack;
    logic [31:0] exp_w [3];
    int acc_c, st_c, req_seen;
    logic last;
    exp_w = '{32'h12021303, 32'h33231101, 32'h31213222};
    acc_ready_i = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int n = 1; n <= 2; n++) begin
      send_beat(8'(n), acc_c);
      req_seen = 0;
      repeat (5) begin
        if (mif.req === 1'b1) req_seen++;
        @(negedge clk);
      end
      total_cnt++; if (req_seen !== 0) $display("FAIL fill_early_write: beat %0d got %0d req cycles want 0", n, req_seen); else pass_cnt++;
    end
    send_beat(8'd3, acc_c);
    wait_start(st_c, last);
    // The pulse sits in the sixth cycle counting the accepting cycle as the first.
    total_cnt++; if (st_c - acc_c !== 5) $display("FAIL fill_latency: got %0d want 5", st_c - acc_c); else pass_cnt++;
    total_cnt++; if (wr_addr_q.size() !== 3) $display("FAIL fill_nwords: got %0d want 3", wr_addr_q.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < wr_addr_q.size(); k++) begin
      total_cnt++; if (wr_addr_q[k] !== 32'(99 + k)) $display("FAIL fill_addr%0d: got %0d want %0d", k, wr_addr_q[k], 99 + k); else pass_cnt++;
      total_cnt++; if (wr_data_q[k] !== exp_w[k]) $display("FAIL fill_data%0d: got %08h want %08h", k, wr_data_q[k], exp_w[k]); else pass_cnt++;
    end
    total_cnt++; if (last !== 1'b0) $display("FAIL fill_last: got %0b want 0", last); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (acc_start_o !== 1'b0) $display("FAIL fill_pulse_width: got %0b want 0", acc_start_o); else pass_cnt++;
    total_cnt++; if (vec_cnt_o !== 2'd1) $display("FAIL fill_vec: got %0d want 1", vec_cnt_o); else pass_cnt++;
  endtask

  task automatic test_sliding;
    logic [31:0] exp_w [3];
    int acc_c, st_c;
    logic last;
    exp_w = '{32'h13031404, 32'h34241202, 32'h32223323};
    wr_addr_q.delete();
    wr_data_q.delete();
    send_beat(8'd4, acc_c);
    wait_start(st_c, last);
    total_cnt++; if (wr_data_q.size() !== 3) $display("FAIL slide_nwords: got %0d want 3", wr_data_q.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < wr_data_q.size(); k++) begin
      total_cnt++; if (wr_data_q[k] !== exp_w[k]) $display("FAIL slide_data%0d: got %08h want %08h", k, wr_data_q[k], exp_w[k]); else pass_cnt++;
    end
    total_cnt++; if (last !== 1'b1) $display("FAIL slide_last: got %0b want 1", last); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (vec_cnt_o !== 2'd0) $display("FAIL slide_vec: got %0d want 0", vec_cnt_o); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int acc_c, st_c, bad;
    logic last;
    acc_ready_i = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_beat(8'd5, acc_c);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (smpl_ready_o !== 1'b0 || mif.req !== 1'b0) bad++;
      @(negedge clk);
    end
    total_cnt++; if (bad !== 0) $display("FAIL bp_hold: got %0d cycles with ready/req high want 0", bad); else pass_cnt++;
    acc_ready_i = 1'b1;
    total_cnt++; if (mif.req !== 1'b0) $display("FAIL bp_rise_req: got %0b want 0", mif.req); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (mif.req !== 1'b1) $display("FAIL bp_write_req: got %0b want 1", mif.req); else pass_cnt++;
    total_cnt++; if (mif.addr !== 32'd99) $display("FAIL bp_write_addr: got %0d want 99", mif.addr); else pass_cnt++;
    total_cnt++; if (mif.data !== 32'h14041505) $display("FAIL bp_write_data: got %08h want 14041505", mif.data); else pass_cnt++;
    wait_start(st_c, last);
    total_cnt++; if (last !== 1'b0) $display("FAIL bp_last: got %0b want 0", last); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (vec_cnt_o !== 2'd1) $display("FAIL bp_vec: got %0d want 1", vec_cnt_o); else pass_cnt++;
  endtask

  task automatic test_ack_stall;
    int acc_c, st_c;
    bit found;
    logic last;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_beat(8'd6, acc_c);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mif.req === 1'b1 && mif.addr === 32'd99) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++; if (!found) $display("FAIL stall_word0: got no word at addr 99 want one"); else pass_cnt++;
    @(posedge clk);
    #1 ack_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total_cnt++; if (mif.req !== 1'b1) $display("FAIL stall%0d_req: got %0b want 1", s, mif.req); else pass_cnt++;
      total_cnt++; if (mif.addr !== 32'd100) $display("FAIL stall%0d_addr: got %0d want 100", s, mif.addr); else pass_cnt++;
      total_cnt++; if (mif.data !== 32'h36261404) $display("FAIL stall%0d_data: got %08h want 36261404", s, mif.data); else pass_cnt++;
      @(posedge clk);
    end
    #1 ack_en = 1'b1;
    @(negedge clk);
    total_cnt++; if (mif.addr !== 32'd100) $display("FAIL stall_release_addr: got %0d want 100", mif.addr); else pass_cnt++;
    wait_start(st_c, last);
    total_cnt++; if (wr_addr_q.size() !== 3) $display("FAIL stall_nwords: got %0d want 3", wr_addr_q.size()); else pass_cnt++;
    total_cnt++; if (last !== 1'b1) $display("FAIL stall_last: got %0b want 1", last); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_integration;
    logic       exp_last [4];
    logic [1:0] exp_vec [4];
    int acc_c, st_c;
    logic last;
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_vec  = '{2'd1, 2'd0, 2'd1, 2'd0};
    for (int v = 0; v < 4; v++) begin
      send_beat(8'(10 + v), acc_c);
      wait_start(st_c, last);
      total_cnt++; if (last !== exp_last[v]) $display("FAIL int_last%0d: got %0b want %0b", v, last, exp_last[v]); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (vec_cnt_o !== exp_vec[v]) $display("FAIL int_vec%0d: got %0d want %0d", v, vec_cnt_o, exp_vec[v]); else pass_cnt++;
    end
  endtask

  task automatic test_clear;
    int acc_c, st_c, starts, req_seen;
    bit found;
    logic last;
    send_beat(8'd14, acc_c);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mif.req === 1'b1 && mif.addr === 32'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++; if (!found) $display("FAIL clr_word1: got no word at addr 100 want one"); else pass_cnt++;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    total_cnt++; if (mif.req !== 1'b0) $display("FAIL clr_req: got %0b want 0", mif.req); else pass_cnt++;
    total_cnt++; if (smpl_ready_o !== 1'b1) $display("FAIL clr_ready: got %0b want 1", smpl_ready_o); else pass_cnt++;
    starts = 0;
    repeat (10) begin
      if (acc_start_o === 1'b1) starts++;
      @(negedge clk);
    end
    total_cnt++; if (starts !== 0) $display("FAIL clr_no_start: got %0d pulses want 0", starts); else pass_cnt++;
    // A beat offered together with clear must not count toward the fill.
    clear_i = 1'b1;
    smpl_valid_i = 1'b1;
    smpl_re_i = 16'hAAAA;
    smpl_im_i = 16'hAAAA;
    @(negedge clk);
    clear_i = 1'b0;
    smpl_valid_i = 1'b0;
    for (int n = 7; n <= 8; n++) begin
      send_beat(8'(n), acc_c);
      req_seen = 0;
      repeat (5) begin
        if (mif.req === 1'b1) req_seen++;
        @(negedge clk);
      end
      total_cnt++; if (req_seen !== 0) $display("FAIL clr_refill%0d: got %0d req cycles want 0", n, req_seen); else pass_cnt++;
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    send_beat(8'd9, acc_c);
    wait_start(st_c, last);
    total_cnt++; if (wr_data_q.size() !== 3) $display("FAIL clr_nwords: got %0d want 3", wr_data_q.size()); else pass_cnt++;
    if (wr_data_q.size() == 3) begin
      total_cnt++; if (wr_data_q[0] !== 32'h18081909) $display("FAIL clr_data0: got %08h want 18081909", wr_data_q[0]); else pass_cnt++;
      total_cnt++; if (wr_data_q[2] !== 32'h37273828) $display("FAIL clr_data2: got %08h want 37273828", wr_data_q[2]); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (vec_cnt_o !== 2'd1) $display("FAIL clr_vec: got %0d want 1", vec_cnt_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int acc_c;
    bit found;
    acc_ready_i = 1'b1;
    send_beat(8'd15, acc_c);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mif.req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++; if (!found) $display("FAIL rstm_write: got no req want one"); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total_cnt++; if (smpl_ready_o !== 1'b1) $display("FAIL rstm_ready: got %0b want 1", smpl_ready_o); else pass_cnt++;
    total_cnt++; if (mif.req !== 1'b0) $display("FAIL rstm_req: got %0b want 0", mif.req); else pass_cnt++;
    total_cnt++; if (mif.we !== 1'b0) $display("FAIL rstm_we: got %0b want 0", mif.we); else pass_cnt++;
    total_cnt++; if (mif.addr !== 32'd0) $display("FAIL rstm_addr: got %0d want 0", mif.addr); else pass_cnt++;
    total_cnt++; if (mif.data !== 32'd0) $display("FAIL rstm_data: got %08h want 0", mif.data); else pass_cnt++;
    total_cnt++; if (acc_start_o !== 1'b0) $display("FAIL rstm_start: got %0b want 0", acc_start_o); else pass_cnt++;
    total_cnt++; if (acc_last_o !== 1'b0) $display("FAIL rstm_last: got %0b want 0", acc_last_o); else pass_cnt++;
    total_cnt++; if (vec_cnt_o !== 2'd0) $display("FAIL rstm_vec: got %0d want 0", vec_cnt_o); else pass_cnt++;
  endtask

  initial begin
    rst          = 1'b0;
    smpl_valid_i = 1'b0;
    smpl_re_i    = '0;
    smpl_im_i    = '0;
    clear_i      = 1'b0;
    acc_ready_i  = 1'b0;
    ack_en       = 1'b1;
    test_reset();
    test_fill_pack();
    test_sliding();
    test_backpressure();
    test_ack_stall();
    test_integration();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
